ahb_slave_mux: RTL

Data-phase response multiplexer for the AHB interconnect. It sits directly downstream of the 4-slave address decoder. It registers the decoder's one-hot `hsel_1..hsel_4` during the address phase and routes the selected slave's `hrdata`/`hreadyout`/`hresp` back to the master during the data phase. An optional watchdog terminates a data phase stalled too long with a two-cycle ERROR response.

---
 rtl/ahb_slave_mux.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mux.sv
// AHB data-phase response mux: registers the decoder's one-hot selects and routes the selected slave's response back to the master.
// Optional stall watchdog compiled in with `define AHB_SLAVE_MUX_TIMEOUT_EN.
module ahb_slave_mux #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [1:0]            htrans,
  input  logic                  hsel_1,
  input  logic                  hsel_2,
  input  logic                  hsel_3,
  input  logic                  hsel_4,
  input  logic [DATA_WIDTH-1:0] hrdata_1,
  input  logic [DATA_WIDTH-1:0] hrdata_2,
  input  logic [DATA_WIDTH-1:0] hrdata_3,
  input  logic [DATA_WIDTH-1:0] hrdata_4,
  input  logic                  hreadyout_1,
  input  logic                  hreadyout_2,
  input  logic                  hreadyout_3,
  input  logic                  hreadyout_4,
  input  logic                  hresp_1,
  input  logic                  hresp_2,
  input  logic                  hresp_3,
  input  logic                  hresp_4,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp,
  output logic                  timeout_seen
);

  logic                  dvalid_q, dvalid_d;
  logic [1:0]            dsel_q, dsel_d;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_ready;
  logic                  sel_resp;
  logic                  err_active;
  logic                  err_ready;

  // Only the NONSEQ/SEQ bit of htrans matters here.
  logic unused_htrans0;
  assign unused_htrans0 = htrans[0];

  always_comb begin : slave_select
    sel_rdata = '0;
    sel_ready = 1'b1;
    sel_resp  = 1'b0;
    case (dsel_q)
      2'd0: begin
        sel_rdata = hrdata_1;
        sel_ready = hreadyout_1;
        sel_resp  = hresp_1;
      end
      2'd1: begin
        sel_rdata = hrdata_2;
        sel_ready = hreadyout_2;
        sel_resp  = hresp_2;
      end
      2'd2: begin
        sel_rdata = hrdata_3;
        sel_ready = hreadyout_3;
        sel_resp  = hresp_3;
      end
      default: begin
        sel_rdata = hrdata_4;
        sel_ready = hreadyout_4;
        sel_resp  = hresp_4;
      end
    endcase
  end

  always_comb begin : select_load
    dvalid_d = dvalid_q;
    dsel_d   = dsel_q;
    if (hready) begin
      dvalid_d = (hsel_1 | hsel_2 | hsel_3 | hsel_4) & htrans[1];
      if (hsel_1)      dsel_d = 2'd0;
      else if (hsel_2) dsel_d = 2'd1;
      else if (hsel_3) dsel_d = 2'd2;
      else if (hsel_4) dsel_d = 2'd3;
      else             dsel_d = 2'd0;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dvalid_q <= 1'b0;
      dsel_q   <= 2'd0;
    end else begin
      dvalid_q <= dvalid_d;
      dsel_q   <= dsel_d;
    end
  end

  // Watchdog responses override the slave entirely, whatever the slave drives.
  always_comb begin : output_mux
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (err_active) begin
      hready = err_ready;
      hresp  = 1'b1;
    end else if (dvalid_q) begin
      hrdata = sel_rdata;
      hready = sel_ready;
      hresp  = sel_resp;
    end
  end

`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
  localparam logic [1:0] ST_PASS = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;
  localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_seen_q, timeout_seen_d;

  assign err_active   = (state_q != ST_PASS);
  assign err_ready    = (state_q == ST_ERR2);
  assign timeout_seen = timeout_seen_q;

  always_comb begin : watchdog
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    timeout_seen_d = timeout_seen_q;
    case (state_q)
      ST_PASS: begin
        if (dvalid_q && !sel_ready) begin
          if (wcnt_q == WCNT_MAX) begin
            state_d = ST_ERR1;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else begin
          wcnt_d = '0;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: begin
        state_d        = ST_PASS;
        timeout_seen_d = 1'b1;
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q        <= ST_PASS;
      wcnt_q         <= '0;
      timeout_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign err_active   = 1'b0;
  assign err_ready    = 1'b0;
  assign timeout_seen = 1'b0;
`endif

endmodule
